// File: rtl/riscv_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_fetch_unit
//  Brief    : Instruction-fetch front end for the Riscv151 core. Owns the PC,
//             drives the icache request port and buffers {pc, instr} pairs in
//             a small FIFO that feeds decode through a valid/ready handshake.
//             Execute-stage redirects flush speculative fetches and resteer
//             the PC. A memory-system stall freezes every piece of state.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = XLEN'(32'h0000_2000),
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    // icache request port
    output logic [XLEN-1:0] icache_addr,
    output logic            icache_re,
    input  logic [XLEN-1:0] icache_dout,
    input  logic            stall,
    // redirect from execute
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    // decode handshake
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_instr
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W:0]   c_OCC_LIMIT = (c_CNT_W + 1)'(DEPTH);
    localparam logic [XLEN-1:0]    c_PC_STEP   = XLEN'(4);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [XLEN-1:0]    r_fetch_pc;     // address of the next request
    logic [XLEN-1:0]    r_req_pc;       // address of the request now in flight
    logic               r_inflight;     // a response lands on the next unstalled edge
    logic [c_CNT_W-1:0] r_count;        // occupied FIFO entries
    logic [c_PTR_W-1:0] r_head;         // oldest entry, presented to decode
    logic [c_PTR_W-1:0] r_tail;         // next free slot
    logic               r_pend_valid;   // redirect seen while stalled
    logic [XLEN-1:0]    r_pend_pc;      // its word-aligned target

    logic [XLEN-1:0]    r_fifo_pc    [DEPTH];
    logic [XLEN-1:0]    r_fifo_instr [DEPTH];

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic [c_CNT_W:0]   w_occ;
    logic               w_issue;
    logic               w_redirect;
    logic [XLEN-1:0]    w_live_target;
    logic [XLEN-1:0]    w_target;
    logic               w_enq;
    logic               w_deq;
    logic               w_unused_lsbs;

    // The low target bits are dropped: fetch addresses are always word aligned.
    assign w_unused_lsbs = ^redirect_pc[1:0];
    assign w_live_target = {redirect_pc[XLEN-1:2], 2'b00};

    // Occupancy counts the in-flight response so that a slot is always
    // reserved for it; a same-cycle dequeue is deliberately not credited.
    assign w_occ      = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_inflight};
    assign w_issue    = reset_n && (w_occ < c_OCC_LIMIT);

    // A live redirect wins over one that was parked during a stall.
    assign w_redirect = !stall && (redirect_valid || r_pend_valid);
    assign w_target   = redirect_valid ? w_live_target : r_pend_pc;

    // A redirect squashes both the arriving response and any dequeue.
    assign w_enq      = !stall && r_inflight && !w_redirect;
    assign w_deq      = dec_valid && dec_ready && !w_redirect;

    assign icache_addr = r_fetch_pc;
    assign icache_re   = w_issue;
    assign dec_valid   = (r_count != '0) && !stall;
    assign dec_pc      = r_fifo_pc[r_head];
    assign dec_instr   = r_fifo_instr[r_head];

    // ------------------------------------------------------------------------
    // Fetch PC, request tracking and resteer
    // ------------------------------------------------------------------------
    // Advance the PC on every accepted request and remember which address is
    // in flight so its response can be tagged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc <= PC_RESET;
            r_req_pc   <= PC_RESET;
            r_inflight <= 1'b0;
        end else if (!stall) begin
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + c_PC_STEP;
                    r_req_pc   <= r_fetch_pc;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------------
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (!stall) begin
            if (w_redirect) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_enq) begin
                    r_tail <= r_tail + c_PTR_ONE;
                end
                if (w_deq) begin
                    r_head <= r_head + c_PTR_ONE;
                end
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + c_CNT_ONE;
                    2'b01:   r_count <= r_count - c_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pending redirect
    // ------------------------------------------------------------------------
    // Park redirects that arrive while stalled (last one wins); the first
    // unstalled edge consumes it together with any live redirect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
        end else if (stall) begin
            if (redirect_valid) begin
                r_pend_valid <= 1'b1;
                r_pend_pc    <= w_live_target;
            end
        end else if (w_redirect) begin
            r_pend_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------------
    // Write the tagged response at the tail; contents need no reset because
    // the occupancy count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_pc[r_tail]    <= r_req_pc;
            r_fifo_instr[r_tail] <= icache_dout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_fetch_unit
//  Brief    : Directed self-checking bench for riscv_fetch_unit with an
//             icache model and an in-order decode scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_fetch_unit;

    localparam logic [31:0] c_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] icache_dout;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          pops     = 0;
    int          p0;
    logic        mon_en;
    logic [31:0] sb [$];
    logic [31:0] last_addr = '0;
    logic [31:0] addr_s;
    logic        re_s;

    riscv_fetch_unit #(
        .XLEN     (32),
        .PC_RESET (32'h0000_2000),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .icache_addr    (icache_addr),
        .icache_re      (icache_re),
        .icache_dout    (icache_dout),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr)
    );

    always #5 clk = ~clk;

    // icache model: data for the address presented on the last unstalled edge
    always @(posedge clk) begin
        if (!stall) last_addr <= icache_addr;
    end
    assign icache_dout = last_addr ^ c_KEY;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seq(input logic [31:0] start);
        sb.delete();
        for (int k = 0; k < 64; k++) sb.push_back(start + 32'(4 * k));
    endtask

    // Scoreboard: every decode handshake must match the next expected PC
    always @(negedge clk) begin
        if (reset_n && mon_en && dec_valid && dec_ready) begin
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_extra: observed pc %h expected no entry", dec_pc);
            end
            if (sb.size() != 0) begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("sb_pc", dec_pc, e);
                chk("sb_instr", dec_instr, e ^ c_KEY);
            end
            pops++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        dec_ready = 1'b0; reset_n = 1'b0; mon_en = 1'b1;
        repeat (3) tick();
        chk("rst_re",   32'(icache_re), 32'd0);
        chk("rst_dv",   32'(dec_valid), 32'd0);
        chk("rst_addr", icache_addr,    32'h2000);

        // Cycle R: first request, decode held off to fill the FIFO
        load_seq(32'h2000);
        reset_n = 1'b1;
        #1;
        chk("r0_re",   32'(icache_re), 32'd1);
        chk("r0_addr", icache_addr,    32'h2000);
        chk("r0_dv",   32'(dec_valid), 32'd0);
        tick();
        chk("r1_dv",   32'(dec_valid), 32'd0);
        chk("r1_addr", icache_addr,    32'h2004);
        tick();
        chk("r2_dv",    32'(dec_valid), 32'd1);
        chk("r2_pc",    dec_pc,         32'h2000);
        chk("r2_instr", dec_instr,      32'h2000 ^ c_KEY);
        repeat (3) tick();
        chk("full_re",   32'(icache_re), 32'd0);
        chk("full_addr", icache_addr,    32'h2010);
        tick(); tick();
        chk("full2_re",   32'(icache_re), 32'd0);
        chk("full2_addr", icache_addr,    32'h2010);
        chk("full2_pc",   dec_pc,         32'h2000);

        // Release decode: one instruction per cycle, no loss or duplication
        p0 = pops;
        dec_ready = 1'b1;
        repeat (5) tick();
        chk("drain_pops", 32'(pops - p0), 32'd5);
        chk("drain_pc",   dec_pc,         32'h2014);

        // Build up 3 entries then redirect to a misaligned target
        dec_ready = 1'b0;
        tick(); tick();
        chk("pre_rd_re", 32'(icache_re), 32'd0);
        dec_ready = 1'b1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h3002; mon_en = 1'b0;
        tick();
        redirect_valid = 1'b0; mon_en = 1'b1;
        load_seq(32'h3000);
        chk("rd1_dv",   32'(dec_valid), 32'd0);
        chk("rd1_addr", icache_addr,    32'h3000);
        tick();
        chk("rd2_dv", 32'(dec_valid), 32'd0);
        tick();
        chk("rd3_dv", 32'(dec_valid), 32'd1);
        chk("rd3_pc", dec_pc,         32'h3000);

        // Five stall cycles with a redirect pulsed in the second one
        repeat (3) tick();
        stall = 1'b1;
        #1;
        addr_s = icache_addr;
        re_s   = icache_re;
        chk("st0_dv", 32'(dec_valid), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            redirect_valid = (i == 1);
            redirect_pc    = 32'h4000;
            chk("st_addr", icache_addr,    addr_s);
            chk("st_re",   32'(icache_re), 32'(re_s));
            chk("st_dv",   32'(dec_valid), 32'd0);
        end
        tick();
        stall = 1'b0; mon_en = 1'b0;
        tick();
        mon_en = 1'b1;
        load_seq(32'h4000);
        chk("sr1_addr", icache_addr,    32'h4000);
        chk("sr1_dv",   32'(dec_valid), 32'd0);
        tick(); tick();
        chk("sr3_dv", 32'(dec_valid), 32'd1);
        chk("sr3_pc", dec_pc,         32'h4000);

        // Asynchronous reset between edges
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        chk("mr_re",   32'(icache_re), 32'd0);
        chk("mr_dv",   32'(dec_valid), 32'd0);
        chk("mr_addr", icache_addr,    32'h2000);
        tick(); tick();
        load_seq(32'h2000);
        reset_n = 1'b1;
        #1;
        chk("rr0_re",   32'(icache_re), 32'd1);
        chk("rr0_addr", icache_addr,    32'h2000);
        tick(); tick();
        chk("rr2_dv", 32'(dec_valid), 32'd1);
        chk("rr2_pc", dec_pc,         32'h2000);

        // PC wrap from the top of the address space
        repeat (2) tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; mon_en = 1'b0;
        tick();
        redirect_valid = 1'b0; mon_en = 1'b1;
        load_seq(32'hFFFF_FFFC);
        chk("w1_addr", icache_addr, 32'hFFFF_FFFC);
        tick();
        chk("w2_addr", icache_addr, 32'h0000_0000);
        tick();
        chk("w3_dv", 32'(dec_valid), 32'd1);
        chk("w3_pc", dec_pc,         32'hFFFF_FFFC);
        tick();
        chk("w4_pc",    dec_pc,    32'h0000_0000);
        chk("w4_instr", dec_instr, 32'hA5A5_0000);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
